// File: rtl/dwt_coef_fifo.sv
// Coefficient buffer behind the recursive DWT core.
// It captures tagged H/L coefficients into a circular buffer and re-presents them
// on a valid/ready interface with a registered first-word-fall-through head.
// It also tracks frame boundaries and flags data loss, because the transform
// cannot be stalled.
module dwt_coef_fifo #(
  parameter int SIZE      = 32,
  parameter int DEPTH     = 16,
  parameter int LVL_W     = 2,
  parameter int FRAME_LEN = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic                       in_hi,
  input  logic [LVL_W-1:0]           in_level,
  input  logic [SIZE-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE-1:0]            out_data,
  output logic                       out_hi,
  output logic [LVL_W-1:0]           out_level,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int WW = SIZE + LVL_W + 1;

  localparam logic [FW-1:0] FILL_ONE   = FW'(1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);

  logic [WW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [FW-1:0] r_fill;
  logic [CW-1:0] r_frame_cnt;
  logic          r_ovf;
  logic [WW-1:0] r_head;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [WW-1:0] w_in_word;
  logic [AW-1:0] w_rd_nxt;
  logic [FW-1:0] w_fill_nxt;
  logic [FW-1:0] w_old_left;
  logic [WW-1:0] w_head_nxt;

  assign w_full    = (r_fill == FILL_FULL);
  assign out_valid = (r_fill != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_push    = in_valid && (!w_full || w_pop);
  assign w_drop    = in_valid && w_full && !w_pop;
  assign w_in_word = {in_hi, in_level, in_data};
  assign w_rd_nxt  = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
  // Entries already stored that survive this cycle's pop.
  assign w_old_left = w_pop ? (r_fill - FILL_ONE) : r_fill;

  assign out_data  = r_head[SIZE-1:0];
  assign out_level = r_head[SIZE +: LVL_W];
  assign out_hi    = r_head[WW-1];
  assign out_last  = out_valid && (r_frame_cnt == FRAME_LAST);
  assign fill      = r_fill;
  assign overflow  = r_ovf;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop) begin
      w_fill_nxt = r_fill + FILL_ONE;
    end else if (w_pop && !w_push) begin
      w_fill_nxt = r_fill - FILL_ONE;
    end
  end

  // Next head word: the oldest surviving entry, or the incoming word when nothing older remains.
  always_comb begin
    w_head_nxt = r_head;
    if (w_old_left != '0) begin
      w_head_nxt = r_mem[w_rd_nxt];
    end else if (w_push) begin
      w_head_nxt = w_in_word;
    end
  end

  // Buffer storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_word;
    end
  end

  // Pointers, occupancy, registered head, frame position and sticky overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_frame_cnt <= '0;
      r_ovf       <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      r_rd_ptr <= w_rd_nxt;
      r_fill   <= w_fill_nxt;
      r_head   <= w_head_nxt;
      if (w_pop) begin
        r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : (r_frame_cnt + CNT_ONE);
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clear_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dwt_coef_fifo.sv
// Bench for dwt_coef_fifo: directed scenarios plus random traffic against a queue model.
module tb_dwt_coef_fifo;

  localparam int SIZE      = 32;
  localparam int DEPTH     = 16;
  localparam int LVL_W     = 2;
  localparam int FRAME_LEN = 64;
  localparam int FW        = $clog2(DEPTH) + 1;

  logic              clk;
  logic              resetn;
  logic              in_valid;
  logic              in_hi;
  logic [LVL_W-1:0]  in_level;
  logic [SIZE-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SIZE-1:0]   out_data;
  logic              out_hi;
  logic [LVL_W-1:0]  out_level;
  logic              out_last;
  logic [FW-1:0]     fill;
  logic              overflow;
  logic              clear_ovf;

  dwt_coef_fifo #(
    .SIZE(SIZE), .DEPTH(DEPTH), .LVL_W(LVL_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_hi(in_hi), .in_level(in_level), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hi(out_hi), .out_level(out_level),
    .out_last(out_last), .fill(fill), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             hi;
    logic [LVL_W-1:0] lvl;
    logic [SIZE-1:0]  data;
  } coef_t;

  // Reference model state
  coef_t mq[$];
  int    m_fpos;
  logic  m_ovf;

  int n_checks;
  int n_errors;

  // Pop bookkeeping for frame-marker placement
  int pop_n;
  int last_pos[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, "_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    check({ph, "_fill"}, 64'(fill), 64'(mq.size()));
    check({ph, "_ovf"}, 64'(overflow), 64'(m_ovf));
    check({ph, "_last"}, 64'(out_last), 64'((mq.size() != 0) && (m_fpos == FRAME_LEN - 1)));
    if (mq.size() != 0) begin
      check({ph, "_data"}, 64'(out_data), 64'(mq[0].data));
      check({ph, "_hi"}, 64'(out_hi), 64'(mq[0].hi));
      check({ph, "_lvl"}, 64'(out_level), 64'(mq[0].lvl));
    end
  endtask

  // One clock: drive inputs, advance the model, clock, then compare.
  task automatic step(input string ph, input logic iv, input logic hi,
                      input logic [LVL_W-1:0] lvl, input logic [SIZE-1:0] d,
                      input logic rdy, input logic clr);
    bit    pop, full, push, drop;
    coef_t c;
    in_valid  = iv;
    in_hi     = hi;
    in_level  = lvl;
    in_data   = d;
    out_ready = rdy;
    clear_ovf = clr;
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    push = iv && (!full || pop);
    drop = iv && full && !pop;
    if (out_valid && out_ready) begin
      pop_n++;
      if (out_last) last_pos.push_back(pop_n);
    end
    if (pop) begin
      void'(mq.pop_front());
      m_fpos = (m_fpos == FRAME_LEN - 1) ? 0 : m_fpos + 1;
    end
    if (push) begin
      c.hi = hi; c.lvl = lvl; c.data = d;
      mq.push_back(c);
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check_outputs(ph);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string ph);
    in_valid  = 1'b0;
    clear_ovf = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check({ph, "_rst_valid"}, 64'(out_valid), 64'(0));
    check({ph, "_rst_fill"}, 64'(fill), 64'(0));
    check({ph, "_rst_ovf"}, 64'(overflow), 64'(0));
    check({ph, "_rst_last"}, 64'(out_last), 64'(0));
    check({ph, "_rst_data"}, 64'(out_data), 64'(0));
    check({ph, "_rst_tags"}, 64'({out_hi, out_level}), 64'(0));
    mq.delete();
    m_fpos = 0;
    m_ovf  = 1'b0;
    pop_n  = 0;
    last_pos.delete();
    @(posedge clk);
    #3;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    pop_n     = 0;
    m_fpos    = 0;
    m_ovf     = 1'b0;
    resetn    = 1'b1;
    in_valid  = 1'b0;
    in_hi     = 1'b0;
    in_level  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset("init");

    // 1: three tagged coefficients straight through
    step("t1", 1'b1, 1'b0, 2'd0, 32'h11, 1'b1, 1'b0);
    step("t1", 1'b1, 1'b1, 2'd0, 32'h22, 1'b1, 1'b0);
    step("t1", 1'b1, 1'b1, 2'd1, 32'h33, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("t1d", 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    check("t1_empty", 64'(fill), 64'(0));

    // 2: fill to DEPTH, one dropped word, then drain
    for (int i = 0; i < DEPTH; i++) step("t2f", 1'b1, i[0], i[1:0], 32'(i), 1'b0, 1'b0);
    check("t2_full", 64'(fill), 64'(DEPTH));
    check("t2_noovf", 64'(overflow), 64'(0));
    step("t2x", 1'b1, 1'b0, 2'd0, 32'h99, 1'b0, 1'b0);
    check("t2_ovf", 64'(overflow), 64'(1));
    for (int i = 0; i < DEPTH + 1; i++) step("t2d", 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);

    // 3: simultaneous push and pop while full
    do_reset("t3");
    for (int i = 0; i < DEPTH; i++) step("t3f", 1'b1, 1'b0, 2'd2, 32'(i + 100), 1'b0, 1'b0);
    step("t3pp", 1'b1, 1'b1, 2'd3, 32'hAA, 1'b1, 1'b0);
    check("t3_fill", 64'(fill), 64'(DEPTH));
    check("t3_ovf", 64'(overflow), 64'(0));
    for (int i = 0; i < DEPTH + 1; i++) step("t3d", 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);

    // 4: continuous streaming across two frame boundaries
    do_reset("t4");
    for (int i = 0; i < 130; i++)
      step("t4", 1'b1, 1'($urandom), 2'($urandom), $urandom, 1'b1, 1'b0);
    step("t4e", 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    check("t4_npops", 64'(pop_n), 64'(130));
    check("t4_nlast", 64'(last_pos.size()), 64'(2));
    if (last_pos.size() == 2) begin
      check("t4_last0", 64'(last_pos[0]), 64'(64));
      check("t4_last1", 64'(last_pos[1]), 64'(128));
    end

    // 5: clear coinciding with a drop loses to the drop
    do_reset("t5");
    for (int i = 0; i < DEPTH + 1; i++) step("t5f", 1'b1, 1'b0, 2'd0, 32'(i), 1'b0, 1'b0);
    check("t5_set", 64'(overflow), 64'(1));
    step("t5c", 1'b1, 1'b0, 2'd0, 32'h55, 1'b0, 1'b1);
    check("t5_hold", 64'(overflow), 64'(1));
    step("t5k", 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    check("t5_clr", 64'(overflow), 64'(0));

    // 6: reset with data buffered, then a fresh frame
    do_reset("t6a");
    for (int i = 0; i < 5; i++) step("t6f", 1'b1, 1'b1, 2'd1, 32'(i + 7), 1'b0, 1'b0);
    do_reset("t6");
    step("t6p", 1'b1, 1'b1, 2'd2, 32'hC0DE, 1'b0, 1'b0);
    check("t6_last", 64'(out_last), 64'(0));
    check("t6_data", 64'(out_data), 64'(32'hC0DE));
    step("t6d", 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);

    // Random traffic with phases favouring fill-up and drain
    for (int i = 0; i < 3000; i++) begin
      int ph_sel;
      logic iv, rdy;
      ph_sel = (i / 200) % 3;
      iv  = ($urandom_range(0, 99) < (ph_sel == 0 ? 85 : (ph_sel == 1 ? 50 : 25)));
      rdy = ($urandom_range(0, 99) < (ph_sel == 0 ? 30 : (ph_sel == 1 ? 50 : 90)));
      step("rnd", iv, 1'($urandom), 2'($urandom), $urandom, rdy,
           ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
